coherent_mem_arbiter: RTL and testbench
=======================================

Name: coherent_mem_arbiter

Overview:
- N-CPU successor to the 2-CPU coherence/RAM arbiter; sits between the per-CPU L1 I/D caches and the single-ported RAM.
- Arbitrates instruction fetches, data fills and writebacks with round-robin fairness.
- Runs snoop-based MSI coherence: snoop broadcast, invalidate, cache-to-cache supply with concurrent RAM update.
- Transfers a parametrised number of words per block.

Parameters:
- CPUS, 2, number of cores; legal range 2..8.
- BLKWORDS, 2, words per cache block moved per transaction; power of 2, at least 1.
- AW, 32, address/data width (word_t).

Ports:
- CLK  in  1  clock
- nRST  in  1  reset; asynchronous, active-low
- iREN  in  CPUS  per-CPU instruction fetch request
- iaddr  in  CPUS*AW  fetch address
- iwait  out  CPUS  low for one cycle when iload is valid
- iload  out  CPUS*AW  fetch data (RAM data broadcast)
- dREN  in  CPUS  data fill request
- dWEN  in  CPUS  data writeback request
- daddr  in  CPUS*AW  current word address; the cache advances it per word
- dstore  in  CPUS*AW  writeback or supply data
- dwait  out  CPUS  low for one cycle per completed word
- dload  out  CPUS*AW  fill data
- cctrans  in  CPUS  coherence transaction request (fill or upgrade)
- ccwrite  in  CPUS  requester: intent to modify; snooped cache: holds line Modified
- ccwait  out  CPUS  freezes a cache while it is being snooped
- ccinv  out  CPUS  invalidate snooped line
- ccsnoopaddr  out  CPUS*AW  snoop address
- ramREN, ramWEN  out  1 each  RAM strobes
- ramaddr, ramstore  out  AW each  RAM address and write data
- ramload  in  AW  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset: state IDLE, rr_ptr=0, word_cnt=0.
  - All outputs while in IDLE with no grant: iwait='1, dwait='1, ccwait=0, ccinv=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ccsnoopaddr=0, dload=0.
  - nRST low mid-transfer aborts to IDLE immediately; no partial completion is signalled.
- Grant (IDLE, one cycle): request classes in priority order dWEN > cctrans > iREN.
  - Within the chosen class, the first requester at or after rr_ptr (wrapping) wins; latch req index.
  - rr_ptr <= req+1 mod CPUS when the transaction completes.
  - Next state: WB, SNOOP or IFETCH.
- WB (writeback):
  - ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req].
  - Each ACCESS: dwait[req]=0, word_cnt++.
  - After BLKWORDS words, go to IDLE.
- SNOOP (1 cycle):
  - All j≠req: ccwait[j]=1, ccsnoopaddr[j]=daddr[req].
  - ccinv[j]=ccwrite[req] (broadcast to all others).
  - Supplier = lowest j≠req with ccwrite[j]=1. If found, go to C2C; else go to FILL.
- C2C (cache-to-cache):
  - Supplier keeps ccwait=1.
  - ramWEN=1, ramaddr=daddr[sup], ramstore=dstore[sup], dload[req]=dstore[sup].
  - Each ACCESS: dwait[req]=0, dwait[sup]=0, word_cnt++.
  - After BLKWORDS words, go to IDLE.
- FILL:
  - ramREN=1, ramaddr=daddr[req], dload[req]=ramload.
  - ACCESS: dwait[req]=0, word_cnt++.
  - After BLKWORDS words, go to IDLE.
  - Snooped caches are released (ccwait=0) on entry.
- IFETCH:
  - Single word: ramREN=1, ramaddr=iaddr[req].
  - iload of all CPUs = ramload; iwait[req]=0 on ACCESS; then go to IDLE.
- General rules:
  - Exactly one dwait/iwait bit may be low in any cycle, except in C2C.
  - ramstate BUSY/FREE: hold state and outputs.
  - ramstate ERROR: retry the same word (no count advance).
  - word_cnt is $clog2(BLKWORDS) bits (min 1), cleared on entry to every transaction state.
  - Requester dropping its request mid-transaction: ignored; the transaction runs to completion.
  - Simultaneous cctrans from all CPUs: served one per transaction in rr order; no starvation beyond CPUS-1 transactions.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined: adds outputs c2c_cnt, fill_cnt, wb_cnt (32 bits each, saturating at 'hFFFF_FFFF).
  - Each increments once per completed transaction of its type.
  - Each resets to 0 on nRST.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package cpu_types_pkg (existing) supplies word_t and ramstate_t.
- New typedef arb_state_t {IDLE, WB, SNOOP, C2C, FILL, IFETCH} and localparam WCNT_W belong in coherence_pkg.
- One sub-module, rr_arbiter: parametrised CPUS-wide round-robin picker.
  - Inputs: req vector, ptr. Outputs: grant index, valid.
  - Instantiated once and shared across the three request classes after the priority mux.

Test Plan:
- CPUS=2, BLKWORDS=2; CPU0 dWEN at daddr 0x100/0x104, dstore 0xAAAA/0xBBBB, RAM ACCESS after 2 BUSY cycles -> RAM gets both words, dwait[0] low twice, then IDLE, rr_ptr=1.
- CPU1 cctrans, ccwrite[1]=0; CPU0 ccwrite=1 for 0x200 with dstore 0xDEAD/0xBEEF -> C2C: dload[1]=0xDEAD then 0xBEEF, RAM written at 0x200/0x204, ccinv[0]=0.
- CPU0 cctrans with ccwrite[0]=1 (upgrade), no supplier -> ccinv[1]=1 in SNOOP, then FILL reads ramload to dload[0].
- CPUS=4; all four assert cctrans continuously -> grants in order 0,1,2,3,0; no CPU waits more than 3 transactions.
- iREN[1] and dREN/cctrans[0] together -> data served first, then iwait[1] low with iload=ramload; nRST pulsed mid-FILL -> all outputs at reset values within the same cycle.
- MC_PERF_CNT_EN defined; 3 fills, 1 C2C -> fill_cnt=3, c2c_cnt=1, wb_cnt=0.

Source files
------------

// File: rtl/coherence_pkg.sv
// Coherence arbiter FSM states and the word-counter width helper.
package coherence_pkg;
   typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, FILL, IFETCH} arb_state_t;

   // A one-word block still needs a 1-bit counter.
   function automatic int wcnt_width(input int blkwords);
      return (blkwords > 1) ? $clog2(blkwords) : 1;
   endfunction
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and RAM handshake status.
package cpu_types_pkg;
   localparam int WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;
   typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/coherent_mem_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int CPUS = 2,
   localparam int IW   = $clog2(CPUS)
) (
   input  logic [CPUS-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   grant,
   output logic            valid
);
   // Scanning from the far end lets the nearest-to-ptr hit overwrite the rest.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = CPUS-1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % CPUS]) begin
            grant = IW'((int'(ptr) + k) % CPUS);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/coherent_mem_arbiter.sv
// N-CPU MSI snoop arbiter in front of a single-ported RAM.
// Define MC_PERF_CNT_EN to add the c2c/fill/wb transaction counters.
module coherent_mem_arbiter
   import cpu_types_pkg::*;
   import coherence_pkg::*;
#(
   parameter int CPUS     = 2,
   parameter int BLKWORDS = 2,
   parameter int AW       = 32
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [CPUS-1:0]    iREN,
   input  logic [CPUS*AW-1:0] iaddr,
   output logic [CPUS-1:0]    iwait,
   output logic [CPUS*AW-1:0] iload,
   input  logic [CPUS-1:0]    dREN,
   input  logic [CPUS-1:0]    dWEN,
   input  logic [CPUS*AW-1:0] daddr,
   input  logic [CPUS*AW-1:0] dstore,
   output logic [CPUS-1:0]    dwait,
   output logic [CPUS*AW-1:0] dload,
   input  logic [CPUS-1:0]    cctrans,
   input  logic [CPUS-1:0]    ccwrite,
   output logic [CPUS-1:0]    ccwait,
   output logic [CPUS-1:0]    ccinv,
   output logic [CPUS*AW-1:0] ccsnoopaddr,
   output logic               ramREN,
   output logic               ramWEN,
   output logic [AW-1:0]      ramaddr,
   output logic [AW-1:0]      ramstore,
   input  logic [AW-1:0]      ramload,
   input  logic [1:0]         ramstate
`ifdef MC_PERF_CNT_EN
  ,output logic [31:0]        c2c_cnt,
   output logic [31:0]        fill_cnt,
   output logic [31:0]        wb_cnt
`endif
);
   localparam int IW     = $clog2(CPUS);
   localparam int WCNT_W = wcnt_width(BLKWORDS);

   arb_state_t        state, nstate, cls_state;
   logic [IW-1:0]     req, sup, sup_idx, rr_ptr, gnt;
   logic [WCNT_W-1:0] word_cnt;
   logic [CPUS-1:0]   cls_vec;
   logic              gnt_vld, sup_found, acc, done;
   logic [AW-1:0]     daddr_req, daddr_sup, dstore_sup;
   ramstate_t         rs;
   logic              unused_dren;

   // Fills arrive as cctrans; dREN carries no extra information here.
   assign unused_dren = ^dREN;
   assign rs          = ramstate_t'(ramstate);
   assign acc         = (rs == ACCESS);
   assign daddr_req   = daddr[int'(req)*AW +: AW];
   assign daddr_sup   = daddr[int'(sup)*AW +: AW];
   assign dstore_sup  = dstore[int'(sup)*AW +: AW];
   assign done = acc && ((state == IFETCH) ||
                 ((state inside {WB, C2C, FILL}) && (word_cnt == WCNT_W'(BLKWORDS-1))));

   always_comb begin
      cls_vec   = iREN;
      cls_state = IFETCH;
      if (|dWEN) begin
         cls_vec   = dWEN;
         cls_state = WB;
      end else if (|cctrans) begin
         cls_vec   = cctrans;
         cls_state = SNOOP;
      end
   end

   rr_arbiter #(.CPUS(CPUS)) u_rr (
      .req   (cls_vec),
      .ptr   (rr_ptr),
      .grant (gnt),
      .valid (gnt_vld)
   );

   always_comb begin
      sup_found = 1'b0;
      sup_idx   = '0;
      for (int j = CPUS-1; j >= 0; j--) begin
         if (j != int'(req) && ccwrite[j]) begin
            sup_found = 1'b1;
            sup_idx   = IW'(j);
         end
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE:    if (gnt_vld) nstate = cls_state;
         SNOOP:   nstate = sup_found ? C2C : FILL;
         default: if (done) nstate = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         req      <= '0;
         sup      <= '0;
         rr_ptr   <= '0;
         word_cnt <= '0;
      end else begin
         state <= nstate;
         if (state == IDLE && gnt_vld) begin
            req      <= gnt;
            word_cnt <= '0;
         end
         if (state == SNOOP) begin
            sup      <= sup_idx;
            word_cnt <= '0;
         end
         if (acc && (state inside {WB, C2C, FILL}))
            word_cnt <= word_cnt + 1'b1;
         if (done)
            rr_ptr <= (req == IW'(CPUS-1)) ? '0 : req + 1'b1;
      end
   end

   always_comb begin
      iwait       = '1;
      dwait       = '1;
      iload       = '0;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;
      case (state)
         WB: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr_req;
            ramstore = dstore[int'(req)*AW +: AW];
            if (acc) dwait[req] = 1'b0;
         end
         SNOOP: begin
            for (int j = 0; j < CPUS; j++) begin
               if (j != int'(req)) begin
                  ccwait[j]                = 1'b1;
                  ccinv[j]                 = ccwrite[req];
                  ccsnoopaddr[j*AW +: AW]  = daddr_req;
               end
            end
         end
         C2C: begin
            // Supplier's data goes to the requester and RAM in the same beat.
            ccwait[sup]               = 1'b1;
            ramWEN                    = 1'b1;
            ramaddr                   = daddr_sup;
            ramstore                  = dstore_sup;
            dload[int'(req)*AW +: AW] = dstore_sup;
            if (acc) begin
               dwait[req] = 1'b0;
               dwait[sup] = 1'b0;
            end
         end
         FILL: begin
            ramREN                    = 1'b1;
            ramaddr                   = daddr_req;
            dload[int'(req)*AW +: AW] = ramload;
            if (acc) dwait[req] = 1'b0;
         end
         IFETCH: begin
            ramREN  = 1'b1;
            ramaddr = iaddr[int'(req)*AW +: AW];
            iload   = {CPUS{ramload}};
            if (acc) iwait[req] = 1'b0;
         end
         default: ;
      endcase
   end

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         c2c_cnt  <= '0;
         fill_cnt <= '0;
         wb_cnt   <= '0;
      end else if (done) begin
         if (state == C2C  && c2c_cnt  != '1) c2c_cnt  <= c2c_cnt  + 1'b1;
         if (state == FILL && fill_cnt != '1) fill_cnt <= fill_cnt + 1'b1;
         if (state == WB   && wb_cnt   != '1) wb_cnt   <= wb_cnt   + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Directed bench: 2-CPU vector table plus 4-CPU round-robin and async-reset sequences.
module tb_coherent_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int F = 0, B = 1, A = 2, E = 3;
   localparam logic [265:0] DEF = {2'b11, 2'b11, 262'h0};

   logic CLK = 1'b0;
   logic nRST;
   always #5 CLK = ~CLK;

   logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite, iwait, dwait, ccwait, ccinv, ramstate;
   logic [63:0] iaddr, daddr, dstore, iload, dload, ccsnoopaddr;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;

   logic [3:0]   iREN4, dREN4, dWEN4, cctrans4, ccwrite4, iwait4, dwait4, ccwait4, ccinv4;
   logic [1:0]   ramstate4;
   logic [127:0] iaddr4, daddr4, dstore4, iload4, dload4, ccsnoopaddr4;
   logic         ramREN4, ramWEN4;
   logic [31:0]  ramaddr4, ramstore4, ramload4;
`ifdef MC_PERF_CNT_EN
   logic [31:0] c2c_cnt, fill_cnt, wb_cnt, c2c_cnt4, fill_cnt4, wb_cnt4;
`endif

   coherent_mem_arbiter #(.CPUS(2), .BLKWORDS(2), .AW(32)) u2 (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef MC_PERF_CNT_EN
     ,.c2c_cnt(c2c_cnt), .fill_cnt(fill_cnt), .wb_cnt(wb_cnt)
`endif
   );

   coherent_mem_arbiter #(.CPUS(4), .BLKWORDS(2), .AW(32)) u4 (
      .CLK(CLK), .nRST(nRST), .iREN(iREN4), .iaddr(iaddr4), .iwait(iwait4), .iload(iload4),
      .dREN(dREN4), .dWEN(dWEN4), .daddr(daddr4), .dstore(dstore4), .dwait(dwait4), .dload(dload4),
      .cctrans(cctrans4), .ccwrite(ccwrite4), .ccwait(ccwait4), .ccinv(ccinv4),
      .ccsnoopaddr(ccsnoopaddr4), .ramREN(ramREN4), .ramWEN(ramWEN4), .ramaddr(ramaddr4),
      .ramstore(ramstore4), .ramload(ramload4), .ramstate(ramstate4)
`ifdef MC_PERF_CNT_EN
     ,.c2c_cnt(c2c_cnt4), .fill_cnt(fill_cnt4), .wb_cnt(wb_cnt4)
`endif
   );

   typedef struct {
      string       nm;
      logic [1:0]  dwen, ctr, cw, ire, rs;
      logic [31:0] da0, ds0, da1, rl;
      logic [1:0]  edw, eiw, eccw, einv;
      logic        ewen, eren;
      logic [31:0] eaddr, estore, edl0, edl1, esn0, esn1, eil;
   } vec_t;

   vec_t tbl [23];
   int   nvec = 0;
   int   nerr = 0;

   function automatic vec_t V(input string nm, input int dwen, ctr, cw, ire, rs,
                              input int unsigned da0, ds0, da1, rl,
                              input int edw, eiw, eccw, einv, ewen, eren,
                              input int unsigned eaddr, estore, edl0, edl1, esn0, esn1, eil);
      vec_t v;
      v.nm = nm;     v.dwen = 2'(dwen); v.ctr = 2'(ctr); v.cw = 2'(cw); v.ire = 2'(ire);
      v.rs = 2'(rs); v.da0 = da0; v.ds0 = ds0; v.da1 = da1; v.rl = rl;
      v.edw = 2'(edw); v.eiw = 2'(eiw); v.eccw = 2'(eccw); v.einv = 2'(einv);
      v.ewen = 1'(ewen); v.eren = 1'(eren); v.eaddr = eaddr; v.estore = estore;
      v.edl0 = edl0; v.edl1 = edl1; v.esn0 = esn0; v.esn1 = esn1; v.eil = eil;
      return v;
   endfunction

   function automatic logic [265:0] outs2();
      return {dwait, iwait, ccwait, ccinv, ramWEN, ramREN, ramaddr, ramstore, dload, ccsnoopaddr, iload};
   endfunction

   task automatic chk(input string nm, input logic [265:0] got, input logic [265:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge CLK);
      dWEN = v.dwen; cctrans = v.ctr; dREN = v.ctr; ccwrite = v.cw; iREN = v.ire;
      ramstate = v.rs; daddr = {v.da1, v.da0}; dstore = {32'h0, v.ds0}; ramload = v.rl;
      #1;
      chk(v.nm, outs2(), {v.edw, v.eiw, v.eccw, v.einv, v.ewen, v.eren, v.eaddr, v.estore,
                          v.edl1, v.edl0, v.esn1, v.esn0, v.eil, v.eil});
   endtask

   initial begin
      logic [3:0] g;
      logic       found;

      tbl[0]  = V("idle0",    0,0,0,0,F, 0,0,0,0,               3,3,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[1]  = V("wb_gnt",   1,0,0,0,F, 'h100,'hAAAA,0,0,      3,3,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[2]  = V("wb_busy1", 1,0,0,0,B, 'h100,'hAAAA,0,0,      3,3,0,0,1,0, 'h100,'hAAAA,0,0,0,0,0);
      tbl[3]  = V("wb_busy2", 1,0,0,0,B, 'h100,'hAAAA,0,0,      3,3,0,0,1,0, 'h100,'hAAAA,0,0,0,0,0);
      tbl[4]  = V("wb_w0",    1,0,0,0,A, 'h100,'hAAAA,0,0,      2,3,0,0,1,0, 'h100,'hAAAA,0,0,0,0,0);
      tbl[5]  = V("wb_w1",    1,0,0,0,A, 'h104,'hBBBB,0,0,      2,3,0,0,1,0, 'h104,'hBBBB,0,0,0,0,0);
      tbl[6]  = V("c2c_gnt",  0,2,1,0,F, 'h200,'hDEAD,'h200,0,  3,3,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[7]  = V("c2c_snoop",0,0,1,0,F, 'h200,'hDEAD,'h200,0,  3,3,1,0,0,0, 0,0,0,0,'h200,0,0);
      tbl[8]  = V("c2c_w0",   0,0,1,0,A, 'h200,'hDEAD,'h200,0,  0,3,1,0,1,0, 'h200,'hDEAD,0,'hDEAD,0,0,0);
      tbl[9]  = V("c2c_w1",   0,0,1,0,A, 'h204,'hBEEF,'h200,0,  0,3,1,0,1,0, 'h204,'hBEEF,0,'hBEEF,0,0,0);
      tbl[10] = V("upg_gnt",  0,1,1,0,F, 'h300,0,0,0,           3,3,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[11] = V("upg_snoop",0,1,1,0,F, 'h300,0,0,0,           3,3,2,2,0,0, 0,0,0,0,0,'h300,0);
      tbl[12] = V("fill_err", 0,1,1,0,E, 'h300,0,0,'h1234,      3,3,0,0,0,1, 'h300,0,'h1234,0,0,0,0);
      tbl[13] = V("fill_w0",  0,1,1,0,A, 'h300,0,0,'h5555,      2,3,0,0,0,1, 'h300,0,'h5555,0,0,0,0);
      tbl[14] = V("fill_w1",  0,1,1,0,A, 'h304,0,0,'h6666,      2,3,0,0,0,1, 'h304,0,'h6666,0,0,0,0);
      tbl[15] = V("mix_gnt",  0,1,0,2,F, 'h500,0,0,0,           3,3,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[16] = V("mix_snoop",0,1,0,2,F, 'h500,0,0,0,           3,3,2,0,0,0, 0,0,0,0,0,'h500,0);
      tbl[17] = V("mix_w0",   0,1,0,2,A, 'h500,0,0,'h7777,      2,3,0,0,0,1, 'h500,0,'h7777,0,0,0,0);
      tbl[18] = V("mix_w1",   0,0,0,2,A, 'h504,0,0,'h8888,      2,3,0,0,0,1, 'h504,0,'h8888,0,0,0,0);
      tbl[19] = V("if_gnt",   0,0,0,2,F, 0,0,0,0,               3,3,0,0,0,0, 0,0,0,0,0,0,0);
      tbl[20] = V("if_busy",  0,0,0,2,B, 0,0,0,'h9999,          3,3,0,0,0,1, 'h400,0,0,0,0,0,'h9999);
      tbl[21] = V("if_w0",    0,0,0,0,A, 0,0,0,'hABCD,          3,1,0,0,0,1, 'h400,0,0,0,0,0,'hABCD);
      tbl[22] = V("idle_end", 0,0,0,0,A, 0,0,0,'h1111,          3,3,0,0,0,0, 0,0,0,0,0,0,0);

      nRST = 1'b0;
      iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; ramstate = 2'(F);
      iaddr = {32'h400, 32'h0}; daddr = '0; dstore = '0; ramload = '0;
      iREN4 = '0; dREN4 = '0; dWEN4 = '0; cctrans4 = '0; ccwrite4 = '0; ramstate4 = 2'(A);
      iaddr4 = '0; daddr4 = '0; dstore4 = '0; ramload4 = '0;
      #12;
      chk("reset", outs2(), DEF);
      @(negedge CLK) nRST = 1'b1;

      for (int i = 0; i < 23; i++) apply(tbl[i]);
`ifdef MC_PERF_CNT_EN
      chk("perf2", {170'h0, wb_cnt, c2c_cnt, fill_cnt}, {170'h0, 32'd1, 32'd1, 32'd2});
`endif

      // Four CPUs hammering cctrans: each SNOOP cycle reveals the requester.
      @(negedge CLK) cctrans4 = 4'hF;
      for (int t = 0; t < 5; t++) begin
         found = 1'b0;
         for (int c = 0; c < 12 && !found; c++) begin
            @(negedge CLK); #1;
            if (ccwait4 != '0) begin
               found = 1'b1;
               g = ~ccwait4;
               chk($sformatf("rr_grant%0d", t), {262'h0, g}, {262'h0, 4'b0001 << (t % 4)});
            end
         end
         if (!found) begin
            nvec++; nerr++;
            $display("FAIL rr_grant%0d: got no snoop within 12 cycles want snoop", t);
         end
      end
      @(negedge CLK) cctrans4 = '0;
      repeat (6) @(negedge CLK);
`ifdef MC_PERF_CNT_EN
      chk("perf4", {170'h0, wb_cnt4, c2c_cnt4, fill_cnt4}, {170'h0, 32'd0, 32'd0, 32'd5});
`endif

      // Asynchronous reset in the middle of a fill.
      @(negedge CLK);
      dWEN = '0; iREN = '0; ccwrite = '0; cctrans = 2'b01; daddr = {32'h0, 32'h600};
      ramstate = 2'(B); ramload = 32'h4242;
      @(negedge CLK);
      @(negedge CLK); #1;
      chk("rst_prefill", {265'h0, ramREN}, {265'h0, 1'b1});
      #1 nRST = 1'b0;
      #1;
      chk("rst_async", outs2(), DEF);
`ifdef MC_PERF_CNT_EN
      chk("rst_perf", {170'h0, wb_cnt, c2c_cnt, fill_cnt}, 266'h0);
`endif
      cctrans = '0;
      #1 nRST = 1'b1;
      @(negedge CLK); #1;
      chk("rst_idle", outs2(), DEF);

      // Both CPUs fetch after reset: pointer back at CPU0.
      iREN = 2'b11; ramstate = 2'(A); ramload = 32'h5A5A;
      @(negedge CLK); #1;
      chk("post_rst_if", {264'h0, iwait}, {264'h0, 2'b10});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
